morph_window_3x3: RTL and testbench

Streaming 3x3 binary-window generator that sits directly upstream of the 3x3 morphology stage. It accepts a raster-order stream of 1-bit pixels from the thresholding/camera path, one pixel per accepted cycle, and keeps two line buffers plus a 3x3 shift array. For every interior pixel it emits the full 3x3 neighbourhood together with the centre coordinates, so the erosion/dilation logic can stay purely combinational on `win`.

---
 rtl/morph_window_3x3.sv | 128 ++++++++++++
 tb/tb_morph_window_3x3.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_window_3x3.sv
// Streaming 3x3 binary window generator: two line buffers plus a shift array,
// one registered window per interior pixel with its centre coordinates.
module morph_window_3x3 #(
    parameter int unsigned IMG_WIDTH  = 630,
    parameter int unsigned IMG_HEIGHT = 390
) (
    input  logic       PixelClk,
    input  logic       nRST,
    input  logic       in_valid,
    input  logic       in_pixel,
    input  logic       in_sof,
    output logic [8:0] win,
    output logic       win_valid,
    output logic [9:0] win_x,
    output logic [9:0] win_y,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned CW = 10;
    localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [1:0]    sh_top;
    logic [1:0]    sh_mid;
    logic [1:0]    sh_bot;
    logic          last_d;

    logic lb1 [IMG_WIDTH];
    logic lb2 [IMG_WIDTH];

    logic          accept;
    logic [CW-1:0] col_eff;
    logic [CW-1:0] row_eff;
    logic [AW-1:0] addr;
    logic          lb1_rd;
    logic          lb2_rd;
    logic          at_last;
    logic          emit;

    // An accepted in_sof pixel is (0,0) regardless of where the counters are.
    always_comb begin
        accept  = in_valid & (in_sof | (state == RUN));
        col_eff = in_sof ? '0 : col;
        row_eff = in_sof ? '0 : row;
        addr    = col_eff[AW-1:0];
        lb1_rd  = lb1[addr];
        lb2_rd  = lb2[addr];
        at_last = (col_eff == CW'(IMG_WIDTH - 1)) && (row_eff == CW'(IMG_HEIGHT - 1));
        emit    = accept && (col_eff >= CW'(2)) && (row_eff >= CW'(2));
    end

    // Line buffers: read-before-write, so LB2 receives the row LB1 held.
    always_ff @(posedge PixelClk) begin
        if (accept) begin
            lb2[addr] <= lb1_rd;
            lb1[addr] <= in_pixel;
        end
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            sh_top     <= '0;
            sh_mid     <= '0;
            sh_bot     <= '0;
            win        <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            last_d     <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            last_d     <= accept & at_last;
            frame_done <= last_d;

            if (in_valid && in_sof) begin
                overrun <= 1'b0;
            end else if (in_valid && (state == DONE)) begin
                overrun <= 1'b1;
            end

            if (accept) begin
                // [1] holds column col-2, [0] holds col-1 relative to the new pixel.
                sh_top <= {sh_top[0], lb2_rd};
                sh_mid <= {sh_mid[0], lb1_rd};
                sh_bot <= {sh_bot[0], in_pixel};

                if (at_last) begin
                    state <= DONE;
                    col   <= '0;
                    row   <= '0;
                end else begin
                    state <= RUN;
                    if (col_eff == CW'(IMG_WIDTH - 1)) begin
                        col <= '0;
                        row <= row_eff + CW'(1);
                    end else begin
                        col <= col_eff + CW'(1);
                        row <= row_eff;
                    end
                end

                if (emit) begin
                    win_valid <= 1'b1;
                    win       <= {in_pixel, sh_bot[0], sh_bot[1],
                                  lb1_rd,   sh_mid[0], sh_mid[1],
                                  lb2_rd,   sh_top[0], sh_top[1]};
                    win_x     <= col_eff - CW'(1);
                    win_y     <= row_eff - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_morph_window_3x3.sv
// Directed bench for morph_window_3x3 on a 5x4 geometry.
module tb_morph_window_3x3;

    localparam int W = 5;
    localparam int H = 4;
    localparam int NPIX = W * H;

    logic       PixelClk = 1'b0;
    logic       nRST;
    logic       in_valid;
    logic       in_pixel;
    logic       in_sof;
    logic [8:0] win;
    logic       win_valid;
    logic [9:0] win_x;
    logic [9:0] win_y;
    logic       frame_done;
    logic       overrun;

    int   checks = 0;
    int   failures = 0;
    int   stream_errs = 0;
    logic [1:0] fd_pipe = 2'b00;
    bit   img [H][W];

    always #5 PixelClk = ~PixelClk;

    morph_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .PixelClk   (PixelClk),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .win        (win),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [8:0] gold(input int x, input int y);
        logic [8:0] g;
        g = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                g[dy*3+dx] = img[y-1+dy][x-1+dx];
        return g;
    endfunction

    // One clock; frame_done is expected two edges after the last pixel.
    task automatic tick(input bit last_acc);
        @(posedge PixelClk);
        #1;
        fd_pipe = {fd_pipe[0], last_acc};
        if (frame_done !== fd_pipe[1]) stream_errs++;
    endtask

    task automatic set_parity();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 1'((r * W + c) % 2);
    endtask

    task automatic set_const(input bit v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = v;
    endtask

    // Streams the first npix pixels of img, starting with in_sof.
    task automatic run_frame(input int duty, input int npix, output int wins, output int nz);
        int r;
        int c;
        int nb;
        wins = 0;
        nz   = 0;
        for (int i = 0; i < npix; i++) begin
            r  = i / W;
            c  = i % W;
            nb = 0;
            while (nb < 4 && int'($urandom_range(99)) < duty) begin
                in_valid = 1'b0;
                in_pixel = 1'($urandom);
                in_sof   = 1'($urandom);
                tick(1'b0);
                if (win_valid !== 1'b0) stream_errs++;
                nb++;
            end
            in_valid = 1'b1;
            in_pixel = img[r][c];
            in_sof   = (i == 0);
            tick(r == H - 1 && c == W - 1);
            if (win_valid === 1'b1) wins++;
            if (c >= 2 && r >= 2) begin
                if (win_valid !== 1'b1 || win !== gold(c - 1, r - 1) ||
                    win_x !== 10'(c - 1) || win_y !== 10'(r - 1)) stream_errs++;
                if (win !== 9'h000) nz++;
            end else if (win_valid !== 1'b0) begin
                stream_errs++;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0;
        fd_pipe = 2'b00;
        tick(1'b0);
        tick(1'b0);
        checks++; if (win !== 9'h000) begin failures++; $display("FAIL reset_win: got %h expected 000", win); end
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
        checks++; if (win_x !== 10'd0) begin failures++; $display("FAIL reset_win_x: got %0d expected 0", win_x); end
        checks++; if (win_y !== 10'd0) begin failures++; $display("FAIL reset_win_y: got %0d expected 0", win_y); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        nRST = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_continuous();
        int e0, wins, nz;
        set_parity();
        e0 = stream_errs;
        run_frame(0, NPIX, wins, nz);
        checks++; if (wins != 6) begin failures++; $display("FAIL cont_wins: got %0d expected 6", wins); end
        // Last centre (3,2): parity of 5*1+2 is odd -> checkerboard 155.
        checks++; if (win !== 9'h155) begin failures++; $display("FAIL cont_last_win: got %h expected 155", win); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL cont_fd_early: got %b expected 0", frame_done); end
        tick(1'b0);
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL cont_fd_pulse: got %b expected 1", frame_done); end
        checks++; if (win_x !== 10'd3 || win_y !== 10'd2) begin failures++; $display("FAIL cont_hold_xy: got %0d,%0d expected 3,2", win_x, win_y); end
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL cont_strobe: got %b expected 0", win_valid); end
        tick(1'b0);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL cont_fd_width: got %b expected 0", frame_done); end
        checks++; if (win !== 9'h155) begin failures++; $display("FAIL cont_hold_win: got %h expected 155", win); end
        checks++; if (stream_errs != e0) begin failures++; $display("FAIL cont_stream: got %0d errors expected 0", stream_errs - e0); end
    endtask

    task automatic test_bubbles();
        int e0, wins, nz;
        set_parity();
        e0 = stream_errs;
        run_frame(50, NPIX, wins, nz);
        repeat (3) tick(1'b0);
        checks++; if (wins != 6) begin failures++; $display("FAIL bub_wins: got %0d expected 6", wins); end
        checks++; if (stream_errs != e0) begin failures++; $display("FAIL bub_stream: got %0d errors expected 0", stream_errs - e0); end
    endtask

    task automatic test_single_one();
        int e0, wins, nz;
        set_const(1'b0);
        img[1][1] = 1'b1;
        e0 = stream_errs;
        run_frame(0, NPIX, wins, nz);
        repeat (3) tick(1'b0);
        checks++; if (nz != 4) begin failures++; $display("FAIL one_nonzero: got %0d expected 4", nz); end
        checks++; if (stream_errs != e0) begin failures++; $display("FAIL one_stream: got %0d errors expected 0", stream_errs - e0); end
    endtask

    task automatic test_all_ones();
        int e0, wins, nz;
        set_const(1'b1);
        e0 = stream_errs;
        run_frame(0, NPIX, wins, nz);
        checks++; if (win !== 9'h1FF) begin failures++; $display("FAIL ones_win: got %h expected 1ff", win); end
        repeat (3) tick(1'b0);
        checks++; if (nz != 6) begin failures++; $display("FAIL ones_count: got %0d expected 6", nz); end
        checks++; if (stream_errs != e0) begin failures++; $display("FAIL ones_stream: got %0d errors expected 0", stream_errs - e0); end
    endtask

    task automatic test_overrun();
        int e0, wins, nz;
        set_parity();
        e0 = stream_errs;
        in_valid = 1'b1; in_sof = 1'b0; in_pixel = 1'b1;
        tick(1'b0);
        in_valid = 1'b0;
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL ovr_dropped: got %b expected 0", win_valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        repeat (2) tick(1'b0);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        run_frame(0, NPIX, wins, nz);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        checks++; if (wins != 6) begin failures++; $display("FAIL ovr_wins: got %0d expected 6", wins); end
        checks++; if (stream_errs != e0) begin failures++; $display("FAIL ovr_stream: got %0d errors expected 0", stream_errs - e0); end
    endtask

    task automatic test_sof_midframe();
        int e0, wins, nz;
        set_parity();
        e0 = stream_errs;
        run_frame(0, 13, wins, nz);
        checks++; if (wins != 1) begin failures++; $display("FAIL mid_partial_wins: got %0d expected 1", wins); end
        set_const(1'b0);
        img[2][3] = 1'b1;
        run_frame(0, NPIX, wins, nz);
        repeat (3) tick(1'b0);
        checks++; if (wins != 6) begin failures++; $display("FAIL mid_wins: got %0d expected 6", wins); end
        checks++; if (nz != 4) begin failures++; $display("FAIL mid_nonzero: got %0d expected 4", nz); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL mid_overrun: got %b expected 0", overrun); end
        checks++; if (stream_errs != e0) begin failures++; $display("FAIL mid_stream: got %0d errors expected 0", stream_errs - e0); end
    endtask

    task automatic test_back_to_back();
        int e0, wins, nz;
        set_parity();
        e0 = stream_errs;
        run_frame(0, NPIX, wins, nz);
        tick(1'b0);
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_fd: got %b expected 1", frame_done); end
        img[3][4] = ~img[3][4];
        run_frame(0, NPIX, wins, nz);
        repeat (3) tick(1'b0);
        checks++; if (wins != 6) begin failures++; $display("FAIL b2b_wins: got %0d expected 6", wins); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        checks++; if (stream_errs != e0) begin failures++; $display("FAIL b2b_stream: got %0d errors expected 0", stream_errs - e0); end
    endtask

    task automatic test_reset_midframe();
        int e0, wins, nz, idle_bad;
        set_const(1'b1);
        e0 = stream_errs;
        idle_bad = 0;
        run_frame(0, 12, wins, nz);
        nRST = 1'b0; in_valid = 1'b1; in_pixel = 1'b1; in_sof = 1'b0;
        fd_pipe = 2'b00;
        tick(1'b0);
        nRST = 1'b1;
        checks++; if (win !== 9'h000 || win_x !== 10'd0 || win_y !== 10'd0) begin failures++; $display("FAIL rstmid_data: got %h,%0d,%0d expected 000,0,0", win, win_x, win_y); end
        checks++; if (win_valid !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rstmid_flags: got %b%b%b expected 000", win_valid, frame_done, overrun); end
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; in_pixel = 1'b1; in_sof = 1'b0;
            tick(1'b0);
            if (win_valid !== 1'b0 || overrun !== 1'b0) idle_bad++;
        end
        in_valid = 1'b0;
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL rstmid_idle: got %0d bad cycles expected 0", idle_bad); end
        run_frame(0, NPIX, wins, nz);
        repeat (3) tick(1'b0);
        checks++; if (wins != 6 || nz != 6) begin failures++; $display("FAIL rstmid_wins: got %0d/%0d expected 6/6", wins, nz); end
        checks++; if (stream_errs != e0) begin failures++; $display("FAIL rstmid_stream: got %0d errors expected 0", stream_errs - e0); end
    endtask

    initial begin
        nRST = 1'b0; in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0;
        test_reset();
        test_continuous();
        test_bubbles();
        test_single_one();
        test_all_ones();
        test_overrun();
        test_sof_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
